// File: rtl/fir_stream_source.sv
// fir_stream_source: AXI-Stream master producing finite test frames
// (impulse, step, ramp, alternating sign) for the FIR filter's sample input.
// Optional feature: define FIR_SRC_TLAST_EN to add m_axis_data_tlast, which
// marks the final sample of each frame.
module fir_stream_source #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 10,
    parameter logic signed [DATA_WIDTH-1:0] AMPLITUDE = 16'sd16384,
    parameter logic signed [DATA_WIDTH-1:0] RAMP_STEP = 16'sd1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                  busy,
    output logic                  done
`ifdef FIR_SRC_TLAST_EN
    ,
    output logic                  m_axis_data_tlast
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] AMP_POS   = AMPLITUDE;
    localparam logic [DATA_WIDTH-1:0] AMP_NEG   = ~AMP_POS + DATA_ONE;
    localparam logic [DATA_WIDTH-1:0] RAMP_INC  = RAMP_STEP;

    state_t                state_r, state_s;
    logic [1:0]            mode_r, mode_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [LEN_WIDTH-1:0]  count_r, count_s;
    logic [LEN_WIDTH-1:0]  next_k_s;
    logic                  tvalid_r, tvalid_s;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
`ifdef FIR_SRC_TLAST_EN
    logic                  tlast_r, tlast_s;
`endif

    // Sample 0 of a frame for the selected waveform.
    function automatic logic [DATA_WIDTH-1:0] first_sample(input logic [1:0] sel);
        logic [DATA_WIDTH-1:0] val;
        case (sel)
            2'd0:    val = AMP_POS;
            2'd1:    val = AMP_POS;
            2'd2:    val = DATA_ZERO;
            2'd3:    val = AMP_POS;
            default: val = DATA_ZERO;
        endcase
        return val;
    endfunction

    // Sample k (k >= 1) derived from the previous sample; the ramp reuses
    // the current output as its accumulator so no multiplier is needed.
    function automatic logic [DATA_WIDTH-1:0] next_sample(
        input logic [1:0]            sel,
        input logic [LEN_WIDTH-1:0]  k,
        input logic [DATA_WIDTH-1:0] cur
    );
        logic [DATA_WIDTH-1:0] val;
        case (sel)
            2'd0:    val = DATA_ZERO;
            2'd1:    val = AMP_POS;
            2'd2:    val = cur + RAMP_INC;
            2'd3:    val = k[0] ? AMP_NEG : AMP_POS;
            default: val = DATA_ZERO;
        endcase
        return val;
    endfunction

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s  = state_r;
        mode_s   = mode_r;
        len_s    = len_r;
        count_s  = count_r;
        tvalid_s = tvalid_r;
        tdata_s  = tdata_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        next_k_s = count_r + LEN_ONE;
`ifdef FIR_SRC_TLAST_EN
        tlast_s  = tlast_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_s  = mode;
                    len_s   = frame_len;
                    count_s = LEN_ZERO;
                    if (frame_len != LEN_ZERO) begin
                        state_s  = ST_SEND;
                        tvalid_s = 1'b1;
                        tdata_s  = first_sample(mode);
                        busy_s   = 1'b1;
`ifdef FIR_SRC_TLAST_EN
                        tlast_s  = (frame_len == LEN_ONE);
`endif
                    end else begin
                        state_s  = ST_DONE;
                        tvalid_s = 1'b0;
                        done_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_s = 1'b1;
                if (tvalid_r && m_axis_data_tready) begin
                    count_s = next_k_s;
                    if (next_k_s == len_r) begin
                        state_s  = ST_DONE;
                        tvalid_s = 1'b0;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
`ifdef FIR_SRC_TLAST_EN
                        tlast_s  = 1'b0;
`endif
                    end else begin
                        tdata_s = next_sample(mode_r, next_k_s, tdata_r);
`ifdef FIR_SRC_TLAST_EN
                        tlast_s = ((next_k_s + LEN_ONE) == len_r);
`endif
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
                count_s  = LEN_ZERO;
`ifdef FIR_SRC_TLAST_EN
                tlast_s  = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers; reset clears everything and abandons any frame.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r  <= ST_IDLE;
            mode_r   <= 2'd0;
            len_r    <= LEN_ZERO;
            count_r  <= LEN_ZERO;
            tvalid_r <= 1'b0;
            tdata_r  <= DATA_ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef FIR_SRC_TLAST_EN
            tlast_r  <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            mode_r   <= mode_s;
            len_r    <= len_s;
            count_r  <= count_s;
            tvalid_r <= tvalid_s;
            tdata_r  <= tdata_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
`ifdef FIR_SRC_TLAST_EN
            tlast_r  <= tlast_s;
`endif
        end
    end

    assign m_axis_data_tvalid = tvalid_r;
    assign m_axis_data_tdata  = tdata_r;
    assign busy               = busy_r;
    assign done               = done_r;
`ifdef FIR_SRC_TLAST_EN
    assign m_axis_data_tlast  = tlast_r;
`endif

endmodule

// File: tb/tb_fir_stream_source.sv
// Self-checking bench for fir_stream_source. Three instances share the
// stimulus and differ only in RAMP_STEP (1, 0x4000, 0x7FFF), so the ramp
// wrap cases are exercised alongside the default build.
module tb_fir_stream_source;

    localparam int NDUT = 3;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       start = 1'b0;
    logic       tready = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] frame_len = 10'd0;

    logic        tvalid_a [NDUT];
    logic [15:0] tdata_a  [NDUT];
    logic        busy_a   [NDUT];
    logic        done_a   [NDUT];
`ifdef FIR_SRC_TLAST_EN
    logic        tlast_a  [NDUT];
`endif

    int step_a [NDUT] = '{1, 16384, 32767};

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_sel = 0;
    int rdy_idx = 0;
    logic [7:0] rdy_pat = 8'b1101_1001;   // cycle order bit0..bit7: 1,0,0,1,1,0,1,1

    always #5 aclk = ~aclk;

    fir_stream_source #(.RAMP_STEP(16'sd1)) dut0 (
        .aclk(aclk), .areset(areset), .start(start), .mode(mode), .frame_len(frame_len),
        .m_axis_data_tvalid(tvalid_a[0]), .m_axis_data_tready(tready),
        .m_axis_data_tdata(tdata_a[0]), .busy(busy_a[0]), .done(done_a[0])
`ifdef FIR_SRC_TLAST_EN
        , .m_axis_data_tlast(tlast_a[0])
`endif
    );

    fir_stream_source #(.RAMP_STEP(16'sh4000)) dut1 (
        .aclk(aclk), .areset(areset), .start(start), .mode(mode), .frame_len(frame_len),
        .m_axis_data_tvalid(tvalid_a[1]), .m_axis_data_tready(tready),
        .m_axis_data_tdata(tdata_a[1]), .busy(busy_a[1]), .done(done_a[1])
`ifdef FIR_SRC_TLAST_EN
        , .m_axis_data_tlast(tlast_a[1])
`endif
    );

    fir_stream_source #(.RAMP_STEP(16'sh7FFF)) dut2 (
        .aclk(aclk), .areset(areset), .start(start), .mode(mode), .frame_len(frame_len),
        .m_axis_data_tvalid(tvalid_a[2]), .m_axis_data_tready(tready),
        .m_axis_data_tdata(tdata_a[2]), .busy(busy_a[2]), .done(done_a[2])
`ifdef FIR_SRC_TLAST_EN
        , .m_axis_data_tlast(tlast_a[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sample k of a frame straight from the waveform definitions.
    function automatic logic [15:0] model(input int m, input int k, input int step);
        int v;
        case (m)
            0:       return (k == 0) ? 16'd16384 : 16'd0;
            1:       return 16'd16384;
            2:       begin v = k * step; return v[15:0]; end
            3:       return (k % 2 == 0) ? 16'd16384 : 16'hC000;
            default: return 16'd0;
        endcase
    endfunction

    task automatic next_ready();
        case (rdy_sel)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 3) != 0);
            default: tready = rdy_pat[rdy_idx % 8];
        endcase
        rdy_idx++;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done);
        for (int i = 0; i < NDUT; i++) begin
            check({tag, "_tvalid"}, 32'(tvalid_a[i]), 32'd0);
            check({tag, "_busy"},   32'(busy_a[i]),   32'd0);
            check({tag, "_done"},   32'(done_a[i]),   32'(exp_done));
`ifdef FIR_SRC_TLAST_EN
            check({tag, "_tlast"},  32'(tlast_a[i]),  32'd0);
`endif
        end
    endtask

    // One frame: start, follow every beat against the model, then the DONE pulse.
    task automatic do_frame(input int m, input int len, input int restart_at);
        int  k;
        int  cyc;
        logic rdy;
        @(negedge aclk);
        start = 1'b1; mode = m[1:0]; frame_len = len[9:0]; tready = 1'b0; rdy_idx = 0;
        @(posedge aclk); #1;
        start = 1'b0;
        mode = 2'($urandom); frame_len = 10'($urandom);   // must not affect the running frame
        for (int i = 0; i < NDUT; i++) begin
            check("start_busy", 32'(busy_a[i]), 32'(len != 0));
            check("start_done", 32'(done_a[i]), 32'(len == 0));
        end
        k = 0; cyc = 0;
        while (k < len && cyc < 5000) begin
            next_ready();
            start = (restart_at >= 0 && cyc == restart_at);
            for (int i = 0; i < NDUT; i++) begin
                check("beat_tvalid", 32'(tvalid_a[i]), 32'd1);
                check("beat_busy",   32'(busy_a[i]),   32'd1);
                check("beat_tdata",  32'(tdata_a[i]),  32'(model(m, k, step_a[i])));
`ifdef FIR_SRC_TLAST_EN
                check("beat_tlast",  32'(tlast_a[i]),  32'(k == len - 1));
`endif
            end
            rdy = tready;
            @(posedge aclk); #1;
            if (rdy) k++;
            cyc++;
        end
        start = 1'b0;
        check("beat_count", 32'(k), 32'(len));
        check_idle_outputs("end", 1'b1);
        @(posedge aclk); #1;
        check_idle_outputs("post", 1'b0);
    endtask

    initial begin
        int m;
        int len;
        areset = 1'b1;
        #2;
        for (int i = 0; i < NDUT; i++) begin
            check("rst_tdata", 32'(tdata_a[i]), 32'd0);
        end
        check_idle_outputs("rst", 1'b0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        rdy_sel = 0; do_frame(0, 4, -1);     // impulse
        rdy_sel = 2; do_frame(2, 5, -1);     // ramp with stall pattern
        rdy_sel = 0; do_frame(3, 3, -1);     // alternating
        do_frame(1, 0, -1);                  // empty frame
        do_frame(1, 8, 3);                   // step, extra start during SEND ignored
        do_frame(0, 1, -1);                  // single-sample frame

        // Asynchronous reset in the middle of a 6-beat step frame.
        @(negedge aclk);
        start = 1'b1; mode = 2'd1; frame_len = 10'd6; tready = 1'b1;
        @(posedge aclk); #1; start = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end
        for (int i = 0; i < NDUT; i++) begin
            check("pre_abort_tvalid", 32'(tvalid_a[i]), 32'd1);
        end
        areset = 1'b1;
        #1;
        check_idle_outputs("abort", 1'b0);
        repeat (3) begin
            @(posedge aclk); #1;
            check_idle_outputs("abort_hold", 1'b0);
        end
        @(negedge aclk);
        areset = 1'b0;
        rdy_sel = 0; do_frame(1, 2, -1);

        do_frame(2, 3, -1);                  // ramp wrap on the larger-step instances

        rdy_sel = 1;
        for (int n = 0; n < 8; n++) begin
            m   = $urandom_range(0, 3);
            len = $urandom_range(0, 40);
            do_frame(m, len, -1);
        end
        do_frame(2, 200, -1);
        rdy_sel = 0; do_frame(2, 1023, -1);  // longest frame

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
